// File: rtl/alu_arbiter_if.sv
// Bundle between the two ALU requesters, the arbiter, and the shared combinational ALU.
// The arbiter takes the slave view and the requesters/ALU take the master view.
interface alu_arbiter_if #(
  parameter int WIDTH = 32,
  parameter int OPW   = 4
);
  logic             req0;
  logic             req1;
  logic [WIDTH-1:0] a0;
  logic [WIDTH-1:0] a1;
  logic [WIDTH-1:0] b0;
  logic [WIDTH-1:0] b1;
  logic [OPW-1:0]   op0;
  logic [OPW-1:0]   op1;
  logic             ack0;
  logic             ack1;
  logic [WIDTH-1:0] result;
  logic             zero;
  logic             err;
  logic             busy;
  logic [WIDTH-1:0] alu_a;
  logic [WIDTH-1:0] alu_b;
  logic [OPW-1:0]   alu_op;
  logic [WIDTH-1:0] alu_result;
  logic             alu_zero;

  modport slave (
    input  req0, req1, a0, a1, b0, b1, op0, op1, alu_result, alu_zero,
    output ack0, ack1, result, zero, err, busy, alu_a, alu_b, alu_op
  );

  modport master (
    output req0, req1, a0, a1, b0, b1, op0, op1, alu_result, alu_zero,
    input  ack0, ack1, result, zero, err, busy, alu_a, alu_b, alu_op
  );
endinterface

// File: rtl/alu_arbiter.sv
// Round-robin sharing of one combinational ALU between two requesters.
// Each grant runs IDLE -> EXEC -> DONE, with a one-cycle ack pulse in DONE.
module alu_arbiter #(
  parameter int WIDTH = 32,
  parameter int OPW   = 4
) (
  input  logic          clk,
  input  logic          rst,
  alu_arbiter_if.slave  bus
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam logic [OPW-1:0] OP_ILLEGAL = 4'b1011;

  state_t           state_q, state_d;
  logic             prio_q, prio_d;
  logic             win_q, win_d;
  logic [WIDTH-1:0] alu_a_q, alu_a_d;
  logic [WIDTH-1:0] alu_b_q, alu_b_d;
  logic [OPW-1:0]   alu_op_q, alu_op_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             zero_q, zero_d;
  logic             err_q, err_d;
  logic             ack0_q, ack0_d;
  logic             ack1_q, ack1_d;
  logic             busy_q, busy_d;
  logic             grant_s;

  // Port 1 wins when it is the only requester, or when both request and prio points at it.
  assign grant_s = bus.req1 & (~bus.req0 | prio_q);

  always_comb begin
    state_d  = state_q;
    prio_d   = prio_q;
    win_d    = win_q;
    alu_a_d  = alu_a_q;
    alu_b_d  = alu_b_q;
    alu_op_d = alu_op_q;
    result_d = result_q;
    zero_d   = zero_q;
    err_d    = err_q;
    ack0_d   = 1'b0;
    ack1_d   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (bus.req0 | bus.req1) begin
          win_d    = grant_s;
          prio_d   = ~grant_s;
          alu_a_d  = grant_s ? bus.a1  : bus.a0;
          alu_b_d  = grant_s ? bus.b1  : bus.b0;
          alu_op_d = grant_s ? bus.op1 : bus.op0;
          state_d  = S_EXEC;
        end else begin
          state_d  = S_IDLE;
        end
      end
      S_EXEC: begin
        result_d = bus.alu_result;
        zero_d   = bus.alu_zero;
        err_d    = (alu_op_q == OP_ILLEGAL);
        ack0_d   = ~win_q;
        ack1_d   = win_q;
        state_d  = S_DONE;
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      prio_q   <= 1'b0;
      win_q    <= 1'b0;
      alu_a_q  <= {WIDTH{1'b0}};
      alu_b_q  <= {WIDTH{1'b0}};
      alu_op_q <= {OPW{1'b0}};
      result_q <= {WIDTH{1'b0}};
      zero_q   <= 1'b0;
      err_q    <= 1'b0;
      ack0_q   <= 1'b0;
      ack1_q   <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      prio_q   <= prio_d;
      win_q    <= win_d;
      alu_a_q  <= alu_a_d;
      alu_b_q  <= alu_b_d;
      alu_op_q <= alu_op_d;
      result_q <= result_d;
      zero_q   <= zero_d;
      err_q    <= err_d;
      ack0_q   <= ack0_d;
      ack1_q   <= ack1_d;
      busy_q   <= busy_d;
    end
  end

  assign bus.alu_a  = alu_a_q;
  assign bus.alu_b  = alu_b_q;
  assign bus.alu_op = alu_op_q;
  assign bus.result = result_q;
  assign bus.zero   = zero_q;
  assign bus.err    = err_q;
  assign bus.ack0   = ack0_q;
  assign bus.ack1   = ack1_q;
  assign bus.busy   = busy_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter with a small behavioural ALU on the shared operand bus.
// Inputs are driven and outputs sampled on the falling edge; the DUT acts on the rising edge.
module tb_alu_arbiter;
  logic clk;
  logic rst;
  int   checks;
  int   fails;

  alu_arbiter_if #(.WIDTH(32), .OPW(4)) bus ();

  alu_arbiter #(.WIDTH(32), .OPW(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference ALU: ADD 0000, AND 0001, OR 0010, SUB 0100, illegal 1011 gives all ones.
  always_comb begin
    case (bus.alu_op)
      4'b0000: bus.alu_result = bus.alu_a + bus.alu_b;
      4'b0001: bus.alu_result = bus.alu_a & bus.alu_b;
      4'b0010: bus.alu_result = bus.alu_a | bus.alu_b;
      4'b0100: bus.alu_result = bus.alu_a - bus.alu_b;
      4'b1011: bus.alu_result = 32'hFFFF_FFFF;
      default: bus.alu_result = 32'h0000_0000;
    endcase
    bus.alu_zero = (bus.alu_result == 32'h0000_0000);
  end

  task automatic idle_inputs();
    bus.req0 = 1'b0; bus.req1 = 1'b0;
    bus.a0 = 32'd0; bus.b0 = 32'd0; bus.op0 = 4'b0000;
    bus.a1 = 32'd0; bus.b1 = 32'd0; bus.op1 = 4'b0000;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checks++; if ({bus.ack0, bus.ack1, bus.busy, bus.err, bus.zero} !== 5'b00000) begin
      fails++; $display("FAIL reset_flags: got %b expected 00000", {bus.ack0, bus.ack1, bus.busy, bus.err, bus.zero}); end
    checks++; if (bus.result !== 32'd0) begin
      fails++; $display("FAIL reset_result: got %h expected 0", bus.result); end
    checks++; if ({bus.alu_a, bus.alu_b, bus.alu_op} !== 68'd0) begin
      fails++; $display("FAIL reset_alu_bus: got %h/%h/%b expected zeros", bus.alu_a, bus.alu_b, bus.alu_op); end
    rst = 1'b0;
  endtask

  task automatic test_single0();
    bus.req0 = 1'b1; bus.a0 = 32'd5; bus.b0 = 32'd3; bus.op0 = 4'b0000;
    @(negedge clk);  // cycle 1: EXEC
    checks++; if ({bus.busy, bus.ack0, bus.ack1} !== 3'b100) begin
      fails++; $display("FAIL s0_exec_flags: got %b expected 100", {bus.busy, bus.ack0, bus.ack1}); end
    checks++; if (bus.alu_a !== 32'd5 || bus.alu_b !== 32'd3 || bus.alu_op !== 4'b0000) begin
      fails++; $display("FAIL s0_alu_bus: got %0d/%0d/%b expected 5/3/0000", bus.alu_a, bus.alu_b, bus.alu_op); end
    @(negedge clk);  // cycle 2: DONE
    checks++; if ({bus.busy, bus.ack0, bus.ack1} !== 3'b110) begin
      fails++; $display("FAIL s0_done_flags: got %b expected 110", {bus.busy, bus.ack0, bus.ack1}); end
    checks++; if (bus.result !== 32'd8 || bus.zero !== 1'b0 || bus.err !== 1'b0) begin
      fails++; $display("FAIL s0_result: got %0d z%b e%b expected 8 z0 e0", bus.result, bus.zero, bus.err); end
    bus.req0 = 1'b0;
    @(negedge clk);  // cycle 3: IDLE, result held
    checks++; if ({bus.busy, bus.ack0, bus.ack1} !== 3'b000 || bus.result !== 32'd8) begin
      fails++; $display("FAIL s0_after: got %b res %0d expected 000 res 8", {bus.busy, bus.ack0, bus.ack1}, bus.result); end
    @(negedge clk);
  endtask

  task automatic test_single1();
    bus.req1 = 1'b1; bus.a1 = 32'd7; bus.b1 = 32'd7; bus.op1 = 4'b0100;
    @(negedge clk);
    checks++; if (bus.alu_a !== 32'd7 || bus.alu_op !== 4'b0100 || bus.ack1 !== 1'b0) begin
      fails++; $display("FAIL s1_exec: got %0d/%b ack1 %b expected 7/0100 ack1 0", bus.alu_a, bus.alu_op, bus.ack1); end
    @(negedge clk);
    checks++; if ({bus.ack0, bus.ack1} !== 2'b01 || bus.result !== 32'd0 || bus.zero !== 1'b1) begin
      fails++; $display("FAIL s1_done: got acks %b res %0d z%b expected 01 res 0 z1", {bus.ack0, bus.ack1}, bus.result, bus.zero); end
    bus.req1 = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_round_robin();
    logic exp0;
    logic exp1;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    bus.req0 = 1'b1; bus.a0 = 32'd1;  bus.b0 = 32'd1; bus.op0 = 4'b0000;
    bus.req1 = 1'b1; bus.a1 = 32'd10; bus.b1 = 32'd3; bus.op1 = 4'b0100;
    for (int c = 1; c <= 12; c++) begin
      @(negedge clk);
      exp0 = (c == 2) || (c == 8);
      exp1 = (c == 5) || (c == 11);
      checks++; if (bus.ack0 !== exp0 || bus.ack1 !== exp1) begin
        fails++; $display("FAIL rr_acks cycle %0d: got %b%b expected %b%b", c, bus.ack0, bus.ack1, exp0, exp1); end
      if (exp0) begin
        checks++; if (bus.result !== 32'd2) begin
          fails++; $display("FAIL rr_res0 cycle %0d: got %0d expected 2", c, bus.result); end
      end
      if (exp1) begin
        checks++; if (bus.result !== 32'd7) begin
          fails++; $display("FAIL rr_res1 cycle %0d: got %0d expected 7", c, bus.result); end
      end
    end
    bus.req0 = 1'b0; bus.req1 = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_illegal_then_reissue();
    bus.req0 = 1'b1; bus.a0 = 32'd0; bus.b0 = 32'd0; bus.op0 = 4'b1011;
    repeat (2) @(negedge clk);  // DONE
    checks++; if (bus.ack0 !== 1'b1 || bus.err !== 1'b1 || bus.result !== 32'hFFFF_FFFF) begin
      fails++; $display("FAIL ill_done: got ack0 %b err %b res %h expected 1 1 ffffffff", bus.ack0, bus.err, bus.result); end
    bus.a0 = 32'd2; bus.b0 = 32'd2; bus.op0 = 4'b0000;  // req0 stays high: new op
    @(negedge clk);  // IDLE, samples new operands
    @(negedge clk);  // EXEC
    checks++; if (bus.alu_a !== 32'd2 || bus.alu_op !== 4'b0000 || bus.err !== 1'b1) begin
      fails++; $display("FAIL reissue_exec: got %0d/%b err %b expected 2/0000 err 1", bus.alu_a, bus.alu_op, bus.err); end
    @(negedge clk);  // DONE
    checks++; if (bus.ack0 !== 1'b1 || bus.err !== 1'b0 || bus.result !== 32'd4) begin
      fails++; $display("FAIL reissue_done: got ack0 %b err %b res %0d expected 1 0 4", bus.ack0, bus.err, bus.result); end
    bus.req0 = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_operand_hold();
    bus.req0 = 1'b1; bus.a0 = 32'd1; bus.b0 = 32'd1; bus.op0 = 4'b0000;
    @(negedge clk);  // EXEC
    bus.a0 = 32'd9;
    @(negedge clk);  // DONE
    checks++; if (bus.ack0 !== 1'b1 || bus.result !== 32'd2 || bus.alu_a !== 32'd1) begin
      fails++; $display("FAIL op_hold: got ack0 %b res %0d alu_a %0d expected 1 2 1", bus.ack0, bus.result, bus.alu_a); end
    bus.req0 = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_reset_abort();
    bus.req0 = 1'b1; bus.a0 = 32'd3; bus.b0 = 32'd4; bus.op0 = 4'b0000;
    @(negedge clk);  // EXEC
    rst = 1'b1;
    @(negedge clk);
    checks++; if ({bus.ack0, bus.ack1, bus.busy, bus.err, bus.zero} !== 5'b00000 || bus.result !== 32'd0 || bus.alu_a !== 32'd0) begin
      fails++; $display("FAIL abort_state: got flags %b res %0d alu_a %0d expected 00000 0 0",
                        {bus.ack0, bus.ack1, bus.busy, bus.err, bus.zero}, bus.result, bus.alu_a); end
    rst = 1'b0;
    bus.req1 = 1'b1; bus.a1 = 32'd6; bus.b1 = 32'd2; bus.op1 = 4'b0010;
    @(negedge clk);  // both requesting, prio back at 0
    @(negedge clk);
    checks++; if ({bus.ack0, bus.ack1} !== 2'b10 || bus.result !== 32'd7) begin
      fails++; $display("FAIL abort_resume: got acks %b res %0d expected 10 res 7", {bus.ack0, bus.ack1}, bus.result); end
    bus.req0 = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if ({bus.ack0, bus.ack1} !== 2'b01 || bus.result !== 32'd6) begin
      fails++; $display("FAIL abort_next1: got acks %b res %0d expected 01 res 6", {bus.ack0, bus.ack1}, bus.result); end
    bus.req1 = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  initial begin
    checks = 0;
    fails  = 0;
    rst    = 1'b1;
    idle_inputs();
    @(negedge clk);
    test_reset();
    test_single0();
    test_single1();
    test_round_robin();
    test_illegal_then_reissue();
    test_operand_hold();
    test_reset_abort();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
